// File: rtl/bsg_front_side_bus_hop_out_multi_if.sv
// rtl/bsg_front_side_bus_hop_out_multi_if.sv - handshake bundle for the multi-source FSB hop output
interface bsg_front_side_bus_hop_out_multi_if #(
  parameter int width_p     = 8,
  parameter int num_local_p = 2
);
  // bit/slice 0 is the upstream switch, 1..num_local_p are local nodes
  logic [num_local_p:0]               v_i;
  logic [(num_local_p+1)*width_p-1:0] data_i;
  logic                               ready_and_o;
  logic [num_local_p-1:0]             yumi_o;
  logic                               v_o;
  logic [width_p-1:0]                 data_o;
  logic                               ready_and_i;

  modport slave (
    input  v_i, data_i, ready_and_i,
    output ready_and_o, yumi_o, v_o, data_o
  );

  modport master (
    output v_i, data_i, ready_and_i,
    input  ready_and_o, yumi_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_front_side_bus_hop_out_multi.sv
// rtl/bsg_front_side_bus_hop_out_multi.sv - upstream + N local ports merged onto one downstream link
module bsg_front_side_bus_hop_out_multi #(
  parameter int width_p        = 8,
  parameter int num_local_p    = 2,
  parameter int fifo_els_p     = 2,
  parameter int starve_limit_p = 1
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_front_side_bus_hop_out_multi_if.slave bus
);

  localparam int lg_local_lp = (num_local_p > 1) ? $clog2(num_local_p) : 1;
  localparam int lg_els_lp   = $clog2(fifo_els_p);
  localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);

  localparam logic [lg_local_lp-1:0] rr_last_lp    = lg_local_lp'(num_local_p - 1);
  localparam logic [lg_els_lp-1:0]   ptr_last_lp   = lg_els_lp'(fifo_els_p - 1);
  localparam logic [cnt_w_lp-1:0]    cnt_full_lp   = cnt_w_lp'(fifo_els_p);
  localparam logic [starve_w_lp-1:0] starve_lim_lp = starve_w_lp'(starve_limit_p);

  logic [width_p-1:0]     mem_r [fifo_els_p];
  logic [lg_els_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0]    count_r;
  logic [lg_local_lp-1:0] rr_r, cand;
  logic [starve_w_lp-1:0] starve_r, starve_n;
  logic                   local_pri_r, local_pri_n;
  logic                   fifo_ready, any_local, grant_up, grant_local, enq, deq;
  logic [num_local_p-1:0] v_local;
  logic [width_p-1:0]     enq_data;
  int                     rot_j;

  assign v_local    = bus.v_i[num_local_p:1];
  assign any_local  = |v_local;
  // Full-FIFO stall is decided from registered occupancy only, so a same-cycle dequeue never frees a slot
  assign fifo_ready = count_r < cnt_full_lp;

  always_comb begin
    cand  = '0;
    rot_j = 0;
    for (int i = num_local_p - 1; i >= 0; i--) begin
      rot_j = int'(rr_r) + i;
      if (rot_j >= num_local_p) rot_j = rot_j - num_local_p;
      if (v_local[rot_j]) cand = rot_j[lg_local_lp-1:0];
    end
  end

  always_comb begin
    grant_up    = 1'b0;
    grant_local = 1'b0;
    if (reset_n_i && fifo_ready) begin
      if (local_pri_r && any_local)  grant_local = 1'b1;
      else if (!local_pri_r && bus.v_i[0]) grant_up = 1'b1;
      else if (any_local)            grant_local = 1'b1;
    end
  end

  assign enq      = grant_up | grant_local;
  assign enq_data = grant_local ? bus.data_i[(int'(cand)+1)*width_p +: width_p]
                                : bus.data_i[width_p-1:0];
  assign deq      = bus.v_o & bus.ready_and_i;

  assign bus.ready_and_o = reset_n_i & fifo_ready & ~local_pri_r;
  assign bus.yumi_o      = grant_local ? (num_local_p'(1) << cand) : '0;
  assign bus.v_o         = reset_n_i & (count_r != '0);
  assign bus.data_o      = mem_r[rd_ptr_r];

  // The priority flag lives exactly one ready slot, so upstream can never be locked out
  always_comb begin
    starve_n    = starve_r;
    local_pri_n = local_pri_r;
    if (fifo_ready) begin
      local_pri_n = 1'b0;
      if (grant_up && any_local) begin
        if (starve_r + starve_w_lp'(1) == starve_lim_lp) begin
          local_pri_n = 1'b1;
          starve_n    = '0;
        end else begin
          starve_n = starve_r + starve_w_lp'(1);
        end
      end else begin
        starve_n = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= enq_data;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      rr_r        <= '0;
      starve_r    <= '0;
      local_pri_r <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= (wr_ptr_r == ptr_last_lp) ? '0 : wr_ptr_r + lg_els_lp'(1);
      if (deq) rd_ptr_r <= (rd_ptr_r == ptr_last_lp) ? '0 : rd_ptr_r + lg_els_lp'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
      if (grant_local) rr_r <= (cand == rr_last_lp) ? '0 : cand + lg_local_lp'(1);
      starve_r    <= starve_n;
      local_pri_r <= local_pri_n;
    end
  end

endmodule
